fifo_stream_adapter: RTL and testbench

FIFO_STREAM_ADAPTER -- requirements
Module: fifo_stream_adapter

---
 rtl/fifo_stream_adapter.sv | 83 ++++++++
 tb/tb_fifo_stream_adapter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_adapter.sv
// Adapts a registered-output FIFO (one-cycle read latency) to a valid/ready stream.
// A 2-entry skid buffer absorbs the in-flight read so full throughput survives backpressure.
module fifo_stream_adapter #(
    parameter int WIDTH     = 32,
    parameter int COUNTBITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     fifo_dataout,
    input  logic                 fifo_empty,
    output logic                 fifo_read,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [COUNTBITS-1:0] xfer_count
);

    logic [WIDTH-1:0]     r_head_p0;
    logic [WIDTH-1:0]     r_tail_p0;
    logic [1:0]           r_count;
    logic                 r_inflight;
    logic                 r_valid;
    logic [COUNTBITS-1:0] r_xfer;

    logic                 w_pop;
    logic [2:0]           w_occ;
    logic                 w_room;
    logic [1:0]           w_cnt_pop;
    logic [1:0]           w_count_nxt;
    logic [WIDTH-1:0]     w_head_nxt;
    logic [WIDTH-1:0]     w_tail_nxt;

    assign w_pop       = r_valid && m_ready;
    // Occupancy counts the word already requested but not yet captured.
    assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_room      = (w_occ - {2'b00, w_pop}) < 3'd2;
    assign fifo_read   = enable && !fifo_empty && !reset && w_room;

    assign w_cnt_pop   = r_count - {1'b0, w_pop};
    assign w_count_nxt = w_cnt_pop + {1'b0, r_inflight};

    always_comb begin
        w_head_nxt = r_head_p0;
        w_tail_nxt = r_tail_p0;
        if (w_pop && (r_count == 2'd2)) begin
            w_head_nxt = r_tail_p0;
        end
        // The arriving word lands just behind whatever survives this cycle's pop.
        if (r_inflight) begin
            if (w_cnt_pop == 2'd0) begin
                w_head_nxt = fifo_dataout;
            end else begin
                w_tail_nxt = fifo_dataout;
            end
        end
    end

    // Buffer storage stage (data path, not reset)
    always_ff @(posedge clk) begin
        r_head_p0 <= w_head_nxt;
        r_tail_p0 <= w_tail_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
            r_xfer     <= '0;
        end else begin
            r_count    <= w_count_nxt;
            r_inflight <= fifo_read;
            r_valid    <= (w_count_nxt != 2'd0);
            r_xfer     <= r_xfer + {{(COUNTBITS-1){1'b0}}, w_pop};
        end
    end

    assign m_data     = r_head_p0;
    assign m_valid    = r_valid;
    assign xfer_count = r_xfer;

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: directed vector table and sequences plus random
// traffic, all checked against a queue-based reference model of the stream.
module tb_fifo_stream_adapter;
    localparam int W  = 32;
    localparam int CB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [W-1:0]  fifo_dataout;
    logic          fifo_empty;
    logic          fifo_read;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic [CB-1:0] xfer_count;

    always #5 clk = ~clk;

    fifo_stream_adapter #(.WIDTH(W), .COUNTBITS(CB)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fifo_dataout (fifo_dataout),
        .fifo_empty   (fifo_empty),
        .fifo_read    (fifo_read),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .xfer_count   (xfer_count)
    );

    // Upstream FIFO with registered read data
    logic [W-1:0] mem [0:4095];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int n_reads = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_read && !fifo_empty) begin
            fifo_dataout <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
            n_reads      <= n_reads + 1;
        end
    end

    task automatic push(input logic [W-1:0] d);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 1;
    endtask

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endfunction

    // Reference model: every word read is owed downstream, visible two cycles
    // after its read, in read order; reset forgives all owed words.
    typedef struct {
        logic [W-1:0] d;
        int           t;
    } ent_t;
    ent_t q[$];
    int   exp_xfer = 0;
    int   n_pops   = 0;
    bit   mon_en   = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mon_en) begin
            bit ev;
            bit ep;
            bit er;
            ev = (q.size() > 0) && (q[0].t <= cyc - 2);
            ep = ev && m_ready;
            er = enable && !fifo_empty && !reset && ((q.size() - int'(ep)) < 2);
            chk("fifo_read", fifo_read, er);
            chk("m_valid", m_valid, ev);
            if (ev) chk("m_data", m_data, q[0].d);
            chk("xfer_count", xfer_count, exp_xfer % (1 << CB));
            if (fifo_read && fifo_empty) chk("read_when_empty", 1, 0);
            if (reset) begin
                q.delete();
                exp_xfer = 0;
            end else begin
                if (ep) begin
                    void'(q.pop_front());
                    exp_xfer = exp_xfer + 1;
                    n_pops   = n_pops + 1;
                end
                if (er) q.push_back('{mem[rd_ptr], cyc});
            end
        end
    end

    typedef struct {
        bit           en;
        bit           rdy;
        bit           rd;
        bit           vld;
        logic [W-1:0] data;
        int           xfer;
    } vec_t;
    vec_t tbl[11];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int base_r;
        int base_p;

        tbl[0]  = '{1, 1, 1, 0, 'h00, 0};
        tbl[1]  = '{1, 1, 1, 0, 'h00, 0};
        tbl[2]  = '{1, 1, 1, 1, 'h10, 0};
        tbl[3]  = '{1, 1, 1, 1, 'h11, 1};
        tbl[4]  = '{1, 1, 1, 1, 'h12, 2};
        tbl[5]  = '{1, 1, 1, 1, 'h13, 3};
        tbl[6]  = '{1, 1, 1, 1, 'h14, 4};
        tbl[7]  = '{1, 1, 1, 1, 'h15, 5};
        tbl[8]  = '{1, 1, 0, 1, 'h16, 6};
        tbl[9]  = '{1, 1, 0, 1, 'h17, 7};
        tbl[10] = '{1, 1, 0, 0, 'h00, 8};

        reset   = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        run(2);
        @(negedge clk);
        chk("rst_fifo_read", fifo_read, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_xfer", xfer_count, 0);
        mon_en = 1;
        step();

        // Streaming vectors
        reset   = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(W'('h10 + i));
        step();
        for (int i = 0; i < 11; i++) begin
            enable  = tbl[i].en;
            m_ready = tbl[i].rdy;
            @(negedge clk);
            chk("vec_read", fifo_read, tbl[i].rd);
            chk("vec_valid", m_valid, tbl[i].vld);
            if (tbl[i].vld) chk("vec_data", m_data, tbl[i].data);
            chk("vec_xfer", xfer_count, tbl[i].xfer);
            step();
        end

        // Counter wrap: 9 more words makes 17 total
        for (int i = 0; i < 9; i++) push(W'('h20 + i));
        run(15);
        @(negedge clk);
        chk("wrap_xfer", xfer_count, 1);
        step();

        // Backpressure
        m_ready = 1'b0;
        base_r  = n_reads;
        base_p  = n_pops;
        for (int i = 0; i < 4; i++) push(W'('hA0 + i));
        run(10);
        @(negedge clk);
        chk("bp_reads", n_reads - base_r, 2);
        chk("bp_valid", m_valid, 1);
        chk("bp_hold", m_data, 'hA0);
        step();
        m_ready = 1'b1;
        run(8);
        chk("bp_pops", n_pops - base_p, 4);

        // Enable dropped while a read is in flight
        enable = 1'b0;
        for (int i = 0; i < 3; i++) push(W'('hB0 + i));
        step();
        base_r = n_reads;
        base_p = n_pops;
        enable = 1'b1;
        step();
        enable = 1'b0;
        run(8);
        chk("en_reads", n_reads - base_r, 1);
        chk("en_pops", n_pops - base_p, 1);
        enable = 1'b1;
        run(6);

        // Toggling ready
        base_p = n_pops;
        for (int i = 0; i < 16; i++) push($urandom);
        for (int i = 0; i < 48; i++) begin
            m_ready = (i % 2 == 0);
            step();
        end
        chk("tog_pops", n_pops - base_p, 16);

        // Reset with a full buffer
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(W'('hC0 + i));
        run(5);
        reset = 1'b1;
        step();
        reset   = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_xfer", xfer_count, 0);
        chk("rst_mid_read", fifo_read, 1);
        run(2);
        @(negedge clk);
        chk("rst_first_valid", m_valid, 1);
        chk("rst_first_data", m_data, 'hC2);
        run(8);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            enable  = ($urandom % 4) != 0;
            m_ready = ($urandom % 3) != 0;
            reset   = ($urandom % 200) == 0;
            if ((($urandom % 3) == 0) && (wr_ptr < 4000)) push($urandom);
            step();
        end

        reset   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        run(12);
        @(negedge clk);
        chk("drain_empty", fifo_empty, 1);
        chk("drain_valid", m_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
